// File: rtl/tetris_pkg.sv
// Shared types and constants for the scoring / level tracker: FSM states,
// BCD digit type, base-point table and default tuning values.
package tetris_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADD,
        ST_LINES,
        ST_LEVEL
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int LINES_PER_LEVEL_DEF = 10;
    localparam int LEVEL_MAX_DEF       = 15;
    localparam int SCORE_DIGITS_DEF    = 6;

    // Base points per report, already in BCD so they feed the BCD adder directly
    localparam logic [15:0] BASE_PTS_1 = 16'h0040;
    localparam logic [15:0] BASE_PTS_2 = 16'h0100;
    localparam logic [15:0] BASE_PTS_3 = 16'h0300;
    localparam logic [15:0] BASE_PTS_4 = 16'h1200;

    function automatic logic lines_meaningful(input logic [2:0] n);
        return (n != 3'd0) && (n <= 3'd4);
    endfunction

    function automatic logic [15:0] base_points(input logic [2:0] n);
        logic [15:0] pts;
        case (n)
            3'd1:    pts = BASE_PTS_1;
            3'd2:    pts = BASE_PTS_2;
            3'd3:    pts = BASE_PTS_3;
            3'd4:    pts = BASE_PTS_4;
            default: pts = 16'h0000;
        endcase
        return pts;
    endfunction

endpackage

// File: rtl/level_tracker_if.sv
// Line-clear report handshake between the playfield logic (master) and the
// level tracker (slave).
interface level_tracker_if;
    logic       clear_valid_i;
    logic [2:0] clear_lines_i;
    logic       clear_ready_o;

    modport master (
        output clear_valid_i,
        output clear_lines_i,
        input  clear_ready_o
    );

    modport slave (
        input  clear_valid_i,
        input  clear_lines_i,
        output clear_ready_o
    );
endinterface

// File: rtl/bcd_add_sat.sv
// Combinational packed-BCD adder, digit 0 in the LSBs; a carry out of the top
// digit saturates the result to all 9s.
module bcd_add_sat
    import tetris_pkg::*;
#(
    parameter int DIGITS = SCORE_DIGITS_DEF
) (
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic [4*DIGITS-1:0] sum
);

    logic [4*DIGITS-1:0] raw;
    logic [4:0]          dsum;
    logic                carry;

    always_comb begin
        raw   = '0;
        dsum  = '0;
        carry = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            dsum = 5'(a[4*i +: 4]) + 5'(b[4*i +: 4]) + 5'(carry);
            // Decimal adjust: skip the six unused codes 10..15
            if (dsum > 5'd9) begin
                dsum  = dsum + 5'd6;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            raw[4*i +: 4] = bcd_digit_t'(dsum[3:0]);
        end
        sum = carry ? {DIGITS{4'h9}} : raw;
    end

endmodule

// File: rtl/level_tracker.sv
// Scoring and level tracker: accumulates BCD score, lines and level from
// line-clear reports. Optional soft-drop points: define SOFT_DROP_POINTS_EN.
module level_tracker
    import tetris_pkg::*;
#(
    parameter int LINES_PER_LEVEL = LINES_PER_LEVEL_DEF,
    parameter int LEVEL_MAX       = LEVEL_MAX_DEF,
    parameter int SCORE_DIGITS    = SCORE_DIGITS_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      game_start_i,
`ifdef SOFT_DROP_POINTS_EN
    input  logic                      drop_i,
`endif
    level_tracker_if.slave            clr,
    output logic [4*SCORE_DIGITS-1:0] score_bcd_o,
    output logic [15:0]               lines_o,
    output logic [3:0]                level_o,
    output logic                      level_changed_o
);

    localparam int SW    = 4 * SCORE_DIGITS;
    // In-level count never exceeds LINES_PER_LEVEL-1 plus the largest report
    localparam int CNT_W = $clog2(LINES_PER_LEVEL + 4) + 1;
    localparam logic [CNT_W-1:0] LPL_C     = CNT_W'(LINES_PER_LEVEL);
    localparam logic [3:0]       LVL_MAX_C = 4'(LEVEL_MAX);

    state_t           state_q;
    logic [2:0]       n_q;
    logic [15:0]      base_q;
    logic [3:0]       iter_q;
    logic [SW-1:0]    score_q;
    logic [15:0]      lines_q;
    logic [3:0]       level_q;
    logic [CNT_W-1:0] inlvl_q;
    logic             level_up_q;
    logic             lvl_chg_q;

    logic             accept;
    logic [SW-1:0]    add_b;
    logic [SW-1:0]    score_sum;
    logic [CNT_W-1:0] inl_sum;

    function automatic logic [15:0] sat_lines(input logic [15:0] cur, input logic [2:0] n);
        logic [16:0] s;
        s = {1'b0, cur} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign clr.clear_ready_o = (state_q == ST_IDLE);
    assign accept            = clr.clear_valid_i && (state_q == ST_IDLE);
    assign inl_sum           = inlvl_q + CNT_W'(n_q);

`ifdef SOFT_DROP_POINTS_EN
    logic drop_pend_q;
    logic drop_serve;

    // A report accepted this cycle wins; the pending point waits for next IDLE
    assign drop_serve = (state_q == ST_IDLE) && !clr.clear_valid_i && drop_pend_q;
    assign add_b      = (state_q == ST_ADD) ? SW'(base_q) : SW'(1);
`else
    assign add_b      = SW'(base_q);
`endif

    bcd_add_sat #(
        .DIGITS (SCORE_DIGITS)
    ) u_add (
        .a   (score_q),
        .b   (add_b),
        .sum (score_sum)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            base_q     <= '0;
            iter_q     <= '0;
            score_q    <= '0;
            lines_q    <= '0;
            level_q    <= '0;
            inlvl_q    <= '0;
            level_up_q <= 1'b0;
            lvl_chg_q  <= 1'b0;
`ifdef SOFT_DROP_POINTS_EN
            drop_pend_q <= 1'b0;
`endif
        end else if (game_start_i) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            base_q     <= '0;
            iter_q     <= '0;
            score_q    <= '0;
            lines_q    <= '0;
            level_q    <= '0;
            inlvl_q    <= '0;
            level_up_q <= 1'b0;
            lvl_chg_q  <= 1'b0;
`ifdef SOFT_DROP_POINTS_EN
            drop_pend_q <= 1'b0;
`endif
        end else begin
            lvl_chg_q <= 1'b0;
`ifdef SOFT_DROP_POINTS_EN
            drop_pend_q <= drop_i || (drop_pend_q && !drop_serve);
`endif
            case (state_q)
                ST_IDLE: begin
                    // Out-of-range line counts are consumed without effect
                    if (accept && lines_meaningful(clr.clear_lines_i)) begin
                        n_q     <= clr.clear_lines_i;
                        base_q  <= base_points(clr.clear_lines_i);
                        iter_q  <= level_q;
                        state_q <= ST_ADD;
                    end
`ifdef SOFT_DROP_POINTS_EN
                    else if (drop_serve) begin
                        score_q <= score_sum;
                    end
`endif
                end
                ST_ADD: begin
                    // Award = base * (level+1) as level+1 successive additions
                    score_q <= score_sum;
                    if (iter_q == 4'd0) begin
                        state_q <= ST_LINES;
                    end else begin
                        iter_q <= iter_q - 4'd1;
                    end
                end
                ST_LINES: begin
                    lines_q <= sat_lines(lines_q, n_q);
                    if (inl_sum >= LPL_C) begin
                        inlvl_q    <= inl_sum - LPL_C;
                        level_up_q <= 1'b1;
                    end else begin
                        inlvl_q <= inl_sum;
                    end
                    state_q <= ST_LEVEL;
                end
                ST_LEVEL: begin
                    if (level_up_q && (level_q < LVL_MAX_C)) begin
                        level_q   <= level_q + 4'd1;
                        lvl_chg_q <= 1'b1;
                    end
                    level_up_q <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign score_bcd_o     = score_q;
    assign lines_o         = lines_q;
    assign level_o         = level_q;
    assign level_changed_o = lvl_chg_q;

endmodule

// File: doc/level_tracker.md
Name: level_tracker

Overview:
Scoring and level tracker: consumes line-clear reports from the playfield logic, accumulates BCD score, total lines and level, and emits the one-cycle level_changed pulse that speeds up the gravity-tick generator. Sits between the line-clear detector and the gravity-tick generator; score, lines and level also feed the HUD renderer. Multi-cycle BCD accumulation FSM with a valid/ready input handshake.

Parameters:
LINES_PER_LEVEL, 10, lines needed to advance one level
LEVEL_MAX, 15, highest level; no advance beyond it
SCORE_DIGITS, 6, BCD digits of score (saturates at all 9s)

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
game_start_i  in  1  synchronous restart pulse; clears all state
clear_valid_i  in  1  line-clear report valid
clear_lines_i  in  3  lines cleared in the report (1..4 meaningful)
clear_ready_o  out  1  tracker can accept a report
score_bcd_o  out  4*SCORE_DIGITS  packed BCD score, digit 0 in LSBs
lines_o  out  16  total lines cleared, saturating at 16'hFFFF
level_o  out  4  current level, 0..LEVEL_MAX
level_changed_o  out  1  one-cycle pulse on level increment

Behaviour:
- Reset (rst_n_i low, async) and game_start_i (sync, highest priority, aborts in-flight work): score 0, lines 0, level 0, in-level line count 0, FSM IDLE, clear_ready_o 1, level_changed_o 0. game_start_i produces no level_changed_o pulse.
- Handshake: report accepted when clear_valid_i && clear_ready_o at a clock edge. clear_ready_o = 1 only in IDLE. Reports with clear_lines_i = 0 or >4 are accepted, discarded, no state change.
- Base points: 1->40, 2->100, 3->300, 4->1200 (BCD constants). Award = base * (level+1), computed by repeated BCD addition.
- FSM:
  IDLE: on valid accepted report, latch n and base, load iter = level -> ADD.
  ADD: score <= sat_bcd(score + base); if iter == 0 -> LINES else iter--, stay. Exactly level+1 ADD cycles.
  LINES: lines_o <= min(lines + n, 16'hFFFF); in-level count += n; if result >= LINES_PER_LEVEL, subtract LINES_PER_LEVEL and set level_up -> LEVEL.
  LEVEL: if level_up and level < LEVEL_MAX: level++, level_changed_o = 1 this cycle only. Clear level_up -> IDLE.
- Latency from acceptance to ready again: level + 3 cycles. level_o and level_changed_o update in the same edge.
- At LEVEL_MAX: lines and score still accumulate; in-level count still wraps; no pulse.
- Score saturation: any BCD carry out of the top digit forces all digits to 9; further adds hold.
- level_changed_o is registered; never asserted for two consecutive cycles.

Optional Feature:
SOFT_DROP_POINTS_EN: adds input drop_i (1 bit); each drop_i pulse sets a pending flag (multiple pulses before service merge into one point). When in IDLE and no report is being accepted this cycle, pending flag adds 1 to score (saturating) and clears; a report accepted in the same cycle takes priority and the flag waits. Without the macro: no drop_i port, no pending flag, score changes only via line clears.

Decomposition:
- Package tetris_pkg: FSM state enum (IDLE, ADD, LINES, LEVEL), BCD digit typedef, base-point BCD constants, LINES_PER_LEVEL/LEVEL_MAX defaults.
- Sub-module bcd_add_sat: combinational SCORE_DIGITS-wide BCD adder with saturate-to-all-9s on overflow; instantiated once in level_tracker.

Test Plan:
- Reset then report n=1 at level 0 -> score 000040, lines 1, clear_ready_o low 3 cycles, no pulse.
- Level 0, three reports n=4 -> after third: lines 12, level 1, in-level count 2, level_changed_o high exactly one cycle, score 003600.
- At level 2, report n=2 -> 3 ADD cycles, score +300, ready returns 5 cycles after acceptance.
- Score preset near 999999 (drive reports to 999960), report n=4 -> score 999999, holds on next report.
- Report n=0 and n=7 -> accepted, no change in score/lines/level; game_start_i asserted mid-ADD -> all outputs 0 next cycle, no pulse.
- With SOFT_DROP_POINTS_EN: drop_i pulses twice while busy -> score +1 after return to IDLE; drop_i coincident with accepted report -> report processed first, point added afterwards.
